phase_readout_controller: RTL and testbench

PHASE_READOUT_CONTROLLER -- requirements
Module: phase_readout_controller

---
 rtl/phase_readout_controller.sv | 157 +++++++++++++++
 tb/tb_phase_readout_controller.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_readout_controller.sv
// phase_readout_controller: moves words from a non-FWFT FIFO to an SPI master, one word per frame.
// Exports the low byte of each sent word as phase_out, counts completed frames and flags a master that never starts.
module phase_readout_controller #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_LATENCY  = 2,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  spi_go,
    output logic [DATA_WIDTH-1:0] spi_data,
    input  logic                  spi_ss_n,
    output logic [7:0]            phase_out,
    output logic                  phase_out_valid,
    output logic [15:0]           frame_count,
    output logic                  timeout_err
);

    localparam int unsigned WAIT_W = $clog2(FIFO_LATENCY + 1);
    localparam int unsigned TMO_W  = $clog2(START_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((FIFO_LATENCY > 1) ? FIFO_LATENCY - 2 : 0);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(START_TIMEOUT - 1);
    localparam logic [7:0]        GAP_LOAD  = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        LOAD,
        BUSY,
        GAP
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  busy_cnt;
    logic [7:0]        gap_cnt;
    logic              seen_low;
    logic              want_read;
    logic              frame_done;
    logic              tmo_hit;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The last GAP cycle makes the IDLE decision itself, so a waiting word costs no extra IDLE cycle.
    always_comb begin
        state_d    = state;
        fifo_rd_en = 1'b0;
        spi_go     = 1'b0;
        frame_done = 1'b0;
        tmo_hit    = 1'b0;
        want_read  = enable && !fifo_empty && !timeout_err;

        unique case (state)
            IDLE: begin
                if (want_read) begin
                    state_d = READ;
                end
            end
            READ: begin
                fifo_rd_en = !rst;
                state_d    = (FIFO_LATENCY > 1) ? WAIT : LOAD;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = BUSY;
            end
            BUSY: begin
                spi_go = !rst && !seen_low && (busy_cnt == '0);
                if (seen_low) begin
                    if (spi_ss_n) begin
                        frame_done = 1'b1;
                        state_d    = GAP;
                    end
                end else if (spi_ss_n && (busy_cnt == TMO_LAST)) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = want_read ? READ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // phase_out_valid is registered so that it pulses in the same cycle the new phase_out appears.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wait_cnt        <= '0;
            busy_cnt        <= '0;
            gap_cnt         <= '0;
            seen_low        <= 1'b0;
            spi_data        <= '0;
            phase_out       <= '0;
            phase_out_valid <= 1'b0;
            frame_count     <= '0;
            timeout_err     <= 1'b0;
        end else begin
            phase_out_valid <= 1'b0;

            if (state == READ) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (state == LOAD) begin
                spi_data        <= fifo_data;
                phase_out       <= fifo_data[7:0];
                phase_out_valid <= 1'b1;
                busy_cnt        <= '0;
                seen_low        <= 1'b0;
            end else if ((state == BUSY) && !seen_low) begin
                if (!spi_ss_n) begin
                    seen_low <= 1'b1;
                end
                if (busy_cnt != TMO_LAST) begin
                    busy_cnt <= busy_cnt + 1'b1;
                end
            end

            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
                gap_cnt     <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_readout_controller.sv
// Bench for phase_readout_controller: FIFO and SPI master models plus an arithmetic model
// of frame order, frame spacing and frame counting.
module tb_phase_readout_controller;

    localparam int DW = 16;
    localparam int L  = 2;
    localparam int G  = 4;
    localparam int ST = 8;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          spi_go;
    logic [DW-1:0] spi_data;
    logic          spi_ss_n = 1'b1;
    logic [7:0]    phase_out;
    logic          phase_out_valid;
    logic [15:0]   frame_count;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    phase_readout_controller #(
        .DATA_WIDTH   (DW),
        .FIFO_LATENCY (L),
        .GAP_CYCLES   (G),
        .START_TIMEOUT(ST)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data      (fifo_data),
        .spi_go         (spi_go),
        .spi_data       (spi_data),
        .spi_ss_n       (spi_ss_n),
        .phase_out      (phase_out),
        .phase_out_valid(phase_out_valid),
        .frame_count    (frame_count),
        .timeout_err    (timeout_err)
    );

    // Non-FWFT FIFO: a read strobed in cycle t shows its word on fifo_data from cycle t+L.
    logic [DW-1:0] mem [0:1023];
    int            push_cnt = 0;
    int            pop_cnt  = 0;
    int            rd_empty_err = 0;
    logic [DW-1:0] pipe_d [L];
    bit            pipe_v [L];

    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge sys_clk) begin
        for (int i = L - 1; i > 0; i--) begin
            pipe_d[i] = pipe_d[i-1];
            pipe_v[i] = pipe_v[i-1];
        end
        pipe_v[0] = 1'b0;
        if (fifo_rd_en === 1'b1) begin
            if (push_cnt == pop_cnt) begin
                rd_empty_err++;
            end else begin
                pipe_d[0] = mem[pop_cnt % 1024];
                pipe_v[0] = 1'b1;
                pop_cnt <= pop_cnt + 1;
            end
        end
        if (pipe_v[L-1]) fifo_data <= pipe_d[L-1];
    end

    // SPI master: ss_n low spi_delay cycles after go, for spi_len cycles.
    int spi_delay = 2;
    int spi_len   = 16;
    bit spi_never = 1'b0;
    bit spi_abort = 1'b0;
    int sp_ph  = 0;
    int sp_cnt = 0;

    always @(posedge sys_clk) begin
        if (spi_abort) begin
            sp_ph = 0;
            spi_ss_n <= 1'b1;
        end else begin
            case (sp_ph)
                0: if (spi_go === 1'b1 && !spi_never) begin
                    if (spi_delay <= 1) begin
                        spi_ss_n <= 1'b0;
                        sp_ph  = 2;
                        sp_cnt = spi_len;
                    end else begin
                        sp_ph  = 1;
                        sp_cnt = spi_delay - 1;
                    end
                end
                1: begin
                    sp_cnt--;
                    if (sp_cnt == 0) begin
                        spi_ss_n <= 1'b0;
                        sp_ph  = 2;
                        sp_cnt = spi_len;
                    end
                end
                default: begin
                    sp_cnt--;
                    if (sp_cnt == 0) begin
                        spi_ss_n <= 1'b1;
                        sp_ph = 0;
                    end
                end
            endcase
        end
    end

    // Event log: cyc is the index of the cycle currently in progress.
    int            cyc   = 0;
    int            n_go  = 0;
    int            n_rd  = 0;
    int            n_pov = 0;
    int            go_cyc [256];
    logic [DW-1:0] go_dat [256];
    logic [7:0]    pov_dat [256];

    always @(posedge sys_clk) begin
        if (spi_go === 1'b1) begin
            go_cyc[n_go % 256] = cyc;
            go_dat[n_go % 256] = spi_data;
            n_go++;
        end
        if (fifo_rd_en === 1'b1) n_rd++;
        if (phase_out_valid === 1'b1) begin
            pov_dat[n_pov % 256] = phase_out;
            n_pov++;
        end
        cyc++;
    end

    logic [15:0] exp_fc = '0;

    task automatic push_word(input logic [DW-1:0] w);
        mem[push_cnt % 1024] = w;
        push_cnt++;
    endtask

    task automatic wait_frame(input logic [15:0] target, input int budget, input string name);
        int k = 0;
        while (frame_count !== target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        n_tests++;
        if (frame_count !== target) begin
            $display("FAIL %s: frame_count=%0d required %0d within %0d cycles", name, frame_count, target, budget);
            n_fail++;
        end
    endtask

    task automatic wait_go(input int target, input int budget, input string name);
        int k = 0;
        while (n_go < target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        n_tests++;
        if (n_go < target) begin
            $display("FAIL %s: spi_go count=%0d required %0d within %0d cycles", name, n_go, target, budget);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_tests += 7;
        if (fifo_rd_en !== 1'b0)      begin $display("FAIL rst_rd_en: got %b need 0", fifo_rd_en); n_fail++; end
        if (spi_go !== 1'b0)          begin $display("FAIL rst_go: got %b need 0", spi_go); n_fail++; end
        if (phase_out_valid !== 1'b0) begin $display("FAIL rst_pov: got %b need 0", phase_out_valid); n_fail++; end
        if (spi_data !== '0)          begin $display("FAIL rst_spi_data: got %h need 0", spi_data); n_fail++; end
        if (phase_out !== 8'h00)      begin $display("FAIL rst_phase: got %h need 0", phase_out); n_fail++; end
        if (frame_count !== 16'd0)    begin $display("FAIL rst_fc: got %0d need 0", frame_count); n_fail++; end
        if (timeout_err !== 1'b0)     begin $display("FAIL rst_tmo: got %b need 0", timeout_err); n_fail++; end
        rst = 1'b0;
        exp_fc = '0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_single_word();
        int bg = n_go;
        int br = n_rd;
        int bp = n_pov;
        int t0;
        spi_delay = 2;
        spi_len   = 16;
        spi_never = 1'b0;
        enable    = 1'b1;
        @(negedge sys_clk);
        t0 = cyc;
        push_word(16'hA5C3);
        exp_fc = exp_fc + 16'd1;
        wait_frame(exp_fc, 200, "single_fc");
        repeat (G + 2) @(negedge sys_clk);
        n_tests += 8;
        if (n_go - bg !== 1)             begin $display("FAIL single_go_cnt: got %0d need 1", n_go - bg); n_fail++; end
        if (go_cyc[bg % 256] !== t0 + L + 2) begin $display("FAIL single_go_cyc: got %0d need %0d", go_cyc[bg % 256], t0 + L + 2); n_fail++; end
        if (go_dat[bg % 256] !== 16'hA5C3)   begin $display("FAIL single_go_data: got %h need a5c3", go_dat[bg % 256]); n_fail++; end
        if (n_rd - br !== 1)             begin $display("FAIL single_rd_cnt: got %0d need 1", n_rd - br); n_fail++; end
        if (n_pov - bp !== 1)            begin $display("FAIL single_pov_cnt: got %0d need 1", n_pov - bp); n_fail++; end
        if (pov_dat[bp % 256] !== 8'hC3) begin $display("FAIL single_pov_data: got %h need c3", pov_dat[bp % 256]); n_fail++; end
        if (spi_data !== 16'hA5C3)       begin $display("FAIL single_hold: got %h need a5c3", spi_data); n_fail++; end
        if (timeout_err !== 1'b0)        begin $display("FAIL single_tmo: got %b need 0", timeout_err); n_fail++; end
    endtask

    task automatic test_burst();
        for (int it = 0; it < 3; it++) begin
            int n  = int'($urandom_range(3, 5));
            int bg = n_go;
            int br = n_rd;
            int bp = n_pov;
            int exp_go;
            int t0;
            logic [DW-1:0] words [5];
            spi_delay = int'($urandom_range(1, 6));
            spi_len   = int'($urandom_range(1, 20));
            @(negedge sys_clk);
            t0 = cyc;
            for (int k = 0; k < n; k++) begin
                words[k] = DW'($urandom);
                push_word(words[k]);
            end
            exp_fc = exp_fc + 16'(n);
            wait_frame(exp_fc, n * 80 + 40, "burst_fc");
            repeat (G + 2) @(negedge sys_clk);
            exp_go = t0 + L + 2;
            for (int k = 0; k < n; k++) begin
                n_tests += 3;
                if (go_cyc[(bg + k) % 256] !== exp_go) begin
                    $display("FAIL burst_go_cyc[%0d]: got %0d need %0d", k, go_cyc[(bg + k) % 256], exp_go); n_fail++;
                end
                if (go_dat[(bg + k) % 256] !== words[k]) begin
                    $display("FAIL burst_go_data[%0d]: got %h need %h", k, go_dat[(bg + k) % 256], words[k]); n_fail++;
                end
                if (pov_dat[(bp + k) % 256] !== words[k][7:0]) begin
                    $display("FAIL burst_pov[%0d]: got %h need %h", k, pov_dat[(bp + k) % 256], words[k][7:0]); n_fail++;
                end
                // one word per (1 + latency + frame + gap) cycles, frame = delay + len + 1 busy cycles
                exp_go = exp_go + 1 + L + (spi_delay + spi_len + 1) + G;
            end
            n_tests += 4;
            if (n_go - bg !== n)      begin $display("FAIL burst_go_cnt: got %0d need %0d", n_go - bg, n); n_fail++; end
            if (n_rd - br !== n)      begin $display("FAIL burst_rd_cnt: got %0d need %0d", n_rd - br, n); n_fail++; end
            if (rd_empty_err !== 0)   begin $display("FAIL burst_rd_empty: got %0d need 0", rd_empty_err); n_fail++; end
            if (fifo_empty !== 1'b1)  begin $display("FAIL burst_fifo_empty: got %b need 1", fifo_empty); n_fail++; end
        end
    endtask

    task automatic test_enable_drop();
        int bg = n_go;
        int br = n_rd;
        logic [DW-1:0] w0 = DW'($urandom);
        logic [DW-1:0] w1 = DW'($urandom);
        spi_delay = 2;
        spi_len   = 16;
        enable    = 1'b1;
        @(negedge sys_clk);
        push_word(w0);
        push_word(w1);
        wait_go(bg + 1, 50, "drop_go");
        enable = 1'b0;
        exp_fc = exp_fc + 16'd1;
        wait_frame(exp_fc, 100, "drop_fc1");
        repeat (60) @(negedge sys_clk);
        n_tests += 5;
        if (frame_count !== exp_fc) begin $display("FAIL drop_fc_hold: got %0d need %0d", frame_count, exp_fc); n_fail++; end
        if (n_rd - br !== 1)        begin $display("FAIL drop_rd_cnt: got %0d need 1", n_rd - br); n_fail++; end
        if (n_go - bg !== 1)        begin $display("FAIL drop_go_cnt: got %0d need 1", n_go - bg); n_fail++; end
        if (go_dat[bg % 256] !== w0) begin $display("FAIL drop_data0: got %h need %h", go_dat[bg % 256], w0); n_fail++; end
        if (fifo_empty !== 1'b0)    begin $display("FAIL drop_fifo: got %b need 0", fifo_empty); n_fail++; end
        enable = 1'b1;
        exp_fc = exp_fc + 16'd1;
        wait_frame(exp_fc, 100, "drop_fc2");
        repeat (G + 2) @(negedge sys_clk);
        n_tests += 2;
        if (n_rd - br !== 2)              begin $display("FAIL drop_rd_cnt2: got %0d need 2", n_rd - br); n_fail++; end
        if (go_dat[(bg + 1) % 256] !== w1) begin $display("FAIL drop_data1: got %h need %h", go_dat[(bg + 1) % 256], w1); n_fail++; end
    endtask

    task automatic test_timeout();
        int bg = n_go;
        int br = n_rd;
        int g;
        int k = 0;
        logic [DW-1:0] w2 = DW'($urandom);
        spi_never = 1'b1;
        enable    = 1'b1;
        @(negedge sys_clk);
        push_word(DW'($urandom));
        wait_go(bg + 1, 50, "tmo_go");
        g = go_cyc[bg % 256];
        while (cyc < g + ST - 1 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        n_tests++;
        if (timeout_err !== 1'b0) begin $display("FAIL tmo_early: got %b need 0 at go+%0d", timeout_err, ST - 1); n_fail++; end
        @(negedge sys_clk);
        n_tests += 2;
        if (timeout_err !== 1'b1)   begin $display("FAIL tmo_set: got %b need 1 at go+%0d", timeout_err, ST); n_fail++; end
        if (frame_count !== exp_fc) begin $display("FAIL tmo_fc: got %0d need %0d", frame_count, exp_fc); n_fail++; end
        push_word(w2);
        repeat (40) @(negedge sys_clk);
        n_tests += 3;
        if (n_rd - br !== 1)      begin $display("FAIL tmo_rd_cnt: got %0d need 1", n_rd - br); n_fail++; end
        if (n_go - bg !== 1)      begin $display("FAIL tmo_go_cnt: got %0d need 1", n_go - bg); n_fail++; end
        if (timeout_err !== 1'b1) begin $display("FAIL tmo_sticky: got %b need 1", timeout_err); n_fail++; end
        spi_never = 1'b0;
        spi_delay = 2;
        spi_len   = 16;
        rst = 1'b1;
        @(negedge sys_clk);
        n_tests++;
        if (timeout_err !== 1'b0) begin $display("FAIL tmo_clear: got %b need 0", timeout_err); n_fail++; end
        rst = 1'b0;
        exp_fc = 16'd1;
        wait_frame(exp_fc, 100, "tmo_recover_fc");
        repeat (G + 2) @(negedge sys_clk);
        n_tests++;
        if (go_dat[(bg + 1) % 256] !== w2) begin $display("FAIL tmo_recover_data: got %h need %h", go_dat[(bg + 1) % 256], w2); n_fail++; end
    endtask

    task automatic test_reset_mid_frame();
        int bg = n_go;
        int t0;
        logic [DW-1:0] w = DW'($urandom);
        spi_delay = 2;
        spi_len   = 16;
        enable    = 1'b1;
        @(negedge sys_clk);
        push_word(DW'($urandom));
        wait_go(bg + 1, 50, "mid_go");
        repeat (5) @(negedge sys_clk);
        rst = 1'b1;
        spi_abort = 1'b1;
        @(negedge sys_clk);
        n_tests += 7;
        if (fifo_rd_en !== 1'b0)      begin $display("FAIL mid_rd_en: got %b need 0", fifo_rd_en); n_fail++; end
        if (spi_go !== 1'b0)          begin $display("FAIL mid_go: got %b need 0", spi_go); n_fail++; end
        if (phase_out_valid !== 1'b0) begin $display("FAIL mid_pov: got %b need 0", phase_out_valid); n_fail++; end
        if (spi_data !== '0)          begin $display("FAIL mid_spi_data: got %h need 0", spi_data); n_fail++; end
        if (phase_out !== 8'h00)      begin $display("FAIL mid_phase: got %h need 0", phase_out); n_fail++; end
        if (frame_count !== 16'd0)    begin $display("FAIL mid_fc: got %0d need 0", frame_count); n_fail++; end
        if (timeout_err !== 1'b0)     begin $display("FAIL mid_tmo: got %b need 0", timeout_err); n_fail++; end
        rst = 1'b0;
        spi_abort = 1'b0;
        exp_fc = 16'd0;
        bg = n_go;
        t0 = cyc;
        push_word(w);
        exp_fc = exp_fc + 16'd1;
        wait_frame(exp_fc, 100, "mid_recover_fc");
        repeat (G + 2) @(negedge sys_clk);
        n_tests += 2;
        if (go_cyc[bg % 256] !== t0 + L + 2) begin $display("FAIL mid_recover_cyc: got %0d need %0d", go_cyc[bg % 256], t0 + L + 2); n_fail++; end
        if (go_dat[bg % 256] !== w)          begin $display("FAIL mid_recover_data: got %h need %h", go_dat[bg % 256], w); n_fail++; end
    endtask

    task automatic test_wrap();
        int bg = n_go;
        logic [DW-1:0] w = DW'($urandom);
        spi_delay = 1;
        spi_len   = 3;
        enable    = 1'b1;
        @(negedge sys_clk);
        force dut.frame_count = 16'hFFFF;
        @(negedge sys_clk);
        release dut.frame_count;
        @(negedge sys_clk);
        n_tests++;
        if (frame_count !== 16'hFFFF) begin $display("FAIL wrap_preload: got %h need ffff", frame_count); n_fail++; end
        push_word(w);
        exp_fc = 16'hFFFF + 16'd1;
        wait_frame(exp_fc, 100, "wrap_fc");
        repeat (G + 2) @(negedge sys_clk);
        n_tests += 2;
        if (frame_count !== 16'd0)  begin $display("FAIL wrap_zero: got %0d need 0", frame_count); n_fail++; end
        if (go_dat[bg % 256] !== w) begin $display("FAIL wrap_data: got %h need %h", go_dat[bg % 256], w); n_fail++; end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        test_reset();
        test_single_word();
        test_burst();
        test_enable_drop();
        test_timeout();
        test_reset_mid_frame();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
